// File: rtl/lc3_ctrl.sv
// ---------------------------------------------------------------------------
// lc3_ctrl
// Multi-cycle control sequencer for a small LC-3 core. It holds PC, IR, MAR,
// MDR and the condition codes. It drives an external memory, an external
// 8x16 register file and an external 2-bit-opcode ALU.
// Each instruction steps through FETCH / DECODE / EVADD / OPERFETCH / STORE.
// Supported instructions: ADD, AND, NOT, BR, LD, ST, LEA, JMP and TRAP.
// TRAP halts the core. Any other opcode halts it and sets the illegal flag.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   i_run             while low the sequencer idles in FETCH
//   o_mem_addr        memory address (low ADDR_W bits of PC or MAR)
//   o_mem_wdata       memory write data (MDR)
//   o_mem_we          memory write strobe; the write lands at the clock edge
//   i_mem_rdata       combinational memory read data for o_mem_addr
//   o_rf_dr/sr1/sr2   register file write / read addresses
//   o_rf_we           register file write enable
//   o_rf_wdata        register file write data
//   i_rf_sr1/2_data   combinational register file read data
//   o_alu_op          ALU operation: 00 ADD, 01 AND, 10 NOT
//   o_alu_a/b         ALU operands
//   i_alu_y           ALU result
//   o_pc, o_ir, o_cc  architectural state (cc = {N,Z,P})
//   o_state           current FSM state (debug / checker visibility)
//   o_halted          sticky; set by TRAP or by an illegal opcode
//   o_illegal         sticky; set by an unsupported opcode
// ---------------------------------------------------------------------------
module lc3_ctrl #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_run,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [15:0]       o_mem_wdata,
    output logic              o_mem_we,
    input  logic [15:0]       i_mem_rdata,
    output logic [2:0]        o_rf_dr,
    output logic [2:0]        o_rf_sr1,
    output logic [2:0]        o_rf_sr2,
    output logic              o_rf_we,
    output logic [15:0]       o_rf_wdata,
    input  logic [15:0]       i_rf_sr1_data,
    input  logic [15:0]       i_rf_sr2_data,
    output logic [1:0]        o_alu_op,
    output logic [15:0]       o_alu_a,
    output logic [15:0]       o_alu_b,
    input  logic [15:0]       i_alu_y,
    output logic [15:0]       o_pc,
    output logic [15:0]       o_ir,
    output logic [2:0]        o_cc,
    output logic [2:0]        o_state,
    output logic              o_halted,
    output logic              o_illegal
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'b000,
        S_DECODE    = 3'b001,
        S_EVADD     = 3'b010,
        S_OPERFETCH = 3'b011,
        S_STORE     = 3'b100,
        S_HALT      = 3'b101
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic [15:0] r_mar;
    logic [15:0] r_mdr;
    logic [2:0]  r_cc;
    logic        r_halted;
    logic        r_illegal;

    logic [3:0]  w_op;
    logic [15:0] w_sext9;
    logic [15:0] w_sext5;
    logic [15:0] w_pc_off;
    logic        w_is_alu;
    logic        w_br_taken;
    logic [2:0]  w_cc_next;
    logic        w_unused_mar;

    assign w_op     = r_ir[15:12];
    assign w_sext9  = {{7{r_ir[8]}}, r_ir[8:0]};
    assign w_sext5  = {{11{r_ir[4]}}, r_ir[4:0]};
    // PC has already been incremented by FETCH, so this is the LC-3
    // PC-relative address for BR, LEA, LD and ST.
    assign w_pc_off = r_pc + w_sext9;
    assign w_is_alu = (w_op == OP_ADD) || (w_op == OP_AND) || (w_op == OP_NOT);
    // IR[11:9] = {n,z,p} lines up bit-for-bit with CC = {N,Z,P}; 000 never branches.
    assign w_br_taken = |(r_ir[11:9] & r_cc);
    assign w_cc_next  = {o_rf_wdata[15], (o_rf_wdata == 16'h0000),
                         ~o_rf_wdata[15] & (o_rf_wdata != 16'h0000)};
    // Only the low ADDR_W bits of MAR reach memory; the rest alias away.
    assign w_unused_mar = ^r_mar;

    assign o_pc        = r_pc;
    assign o_ir        = r_ir;
    assign o_cc        = r_cc;
    assign o_state     = r_state;
    assign o_halted    = r_halted;
    assign o_illegal   = r_illegal;
    assign o_mem_wdata = r_mdr;
    assign o_rf_dr     = r_ir[11:9];
    assign o_rf_sr2    = r_ir[2:0];
    assign o_alu_a     = i_rf_sr1_data;

    // Datapath steering: Moore-style decode of state and IR.
    always_comb begin
        o_mem_addr = r_pc[ADDR_W-1:0];
        o_mem_we   = 1'b0;
        o_rf_we    = 1'b0;
        o_rf_sr1   = r_ir[8:6];
        o_alu_op   = 2'b00;
        o_alu_b    = r_ir[5] ? w_sext5 : i_rf_sr2_data;
        o_rf_wdata = i_alu_y;

        case (w_op)
            OP_AND:  o_alu_op = 2'b01;
            OP_NOT:  o_alu_op = 2'b10;
            default: o_alu_op = 2'b00;
        endcase

        if (w_op == OP_NOT) begin
            o_alu_b = 16'h0000;
        end

        case (w_op)
            OP_LD:   o_rf_wdata = r_mdr;
            OP_LEA:  o_rf_wdata = w_pc_off;
            default: o_rf_wdata = i_alu_y;
        endcase

        // EVADD reads the ST source register; every other state reads the
        // SR1/BaseR field.
        if (r_state == S_EVADD) begin
            o_rf_sr1 = r_ir[11:9];
        end

        if (r_state == S_OPERFETCH || (r_state == S_STORE && w_op == OP_ST)) begin
            o_mem_addr = r_mar[ADDR_W-1:0];
        end

        if (r_state == S_STORE) begin
            o_mem_we = (w_op == OP_ST);
            o_rf_we  = w_is_alu || (w_op == OP_LD) || (w_op == OP_LEA);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_pc      <= 16'h0000;
            r_ir      <= 16'h0000;
            r_mar     <= 16'h0000;
            r_mdr     <= 16'h0000;
            r_cc      <= 3'b010;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (o_rf_we) begin
                r_cc <= w_cc_next;
            end

            case (r_state)
                S_FETCH: begin
                    if (i_run) begin
                        r_ir    <= i_mem_rdata;
                        r_pc    <= r_pc + 16'd1;
                        r_state <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    case (w_op)
                        OP_ADD, OP_AND, OP_NOT, OP_BR, OP_LEA, OP_JMP:
                            r_state <= S_STORE;
                        OP_LD, OP_ST:
                            r_state <= S_EVADD;
                        OP_TRAP: begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end
                        default: begin
                            r_state   <= S_HALT;
                            r_halted  <= 1'b1;
                            r_illegal <= 1'b1;
                        end
                    endcase
                end

                S_EVADD: begin
                    r_mar <= w_pc_off;
                    if (w_op == OP_ST) begin
                        r_mdr   <= i_rf_sr1_data;
                        r_state <= S_STORE;
                    end else begin
                        r_state <= S_OPERFETCH;
                    end
                end

                S_OPERFETCH: begin
                    r_mdr   <= i_mem_rdata;
                    r_state <= S_STORE;
                end

                S_STORE: begin
                    if (w_op == OP_BR && w_br_taken) begin
                        r_pc <= w_pc_off;
                    end else if (w_op == OP_JMP) begin
                        r_pc <= i_rf_sr1_data;
                    end
                    r_state <= S_FETCH;
                end

                S_HALT: begin
                    r_state <= S_HALT;
                end

                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lc3_ctrl
// Bench for lc3_ctrl. It provides a 128x16 memory, an 8x16 register file and
// an ALU around the sequencer. An instruction-level LC-3 model keeps its own
// copy of memory, registers, PC and CC, and predicts each instruction's
// effect and cycle count. Directed programs cover the listed scenarios, and
// randomized programs cover the broader instruction mix.
// ---------------------------------------------------------------------------
module tb_lc3_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [6:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic [2:0]  rf_dr, rf_sr1, rf_sr2;
    logic        rf_we;
    logic [15:0] rf_wdata, rf_sr1_data, rf_sr2_data;
    logic [1:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_y;
    logic [15:0] pc, ir;
    logic [2:0]  cc, state;
    logic        halted, illegal;

    // Environment memories plus a load channel, so that one process owns them.
    logic [15:0] tb_mem [128];
    logic [15:0] tb_rf  [8];
    logic        ld_mem = 1'b0;
    logic        ld_rf  = 1'b0;
    logic [6:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;

    // Instruction-level reference model state.
    logic [15:0] m_mem [128];
    logic [15:0] m_rf  [8];
    logic [15:0] m_pc;
    logic [2:0]  m_cc;
    logic        m_halted;
    logic        m_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lc3_ctrl #(.ADDR_W(7)) dut (
        .clk(clk), .rst(rst), .i_run(run),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
        .i_mem_rdata(mem_rdata),
        .o_rf_dr(rf_dr), .o_rf_sr1(rf_sr1), .o_rf_sr2(rf_sr2),
        .o_rf_we(rf_we), .o_rf_wdata(rf_wdata),
        .i_rf_sr1_data(rf_sr1_data), .i_rf_sr2_data(rf_sr2_data),
        .o_alu_op(alu_op), .o_alu_a(alu_a), .o_alu_b(alu_b), .i_alu_y(alu_y),
        .o_pc(pc), .o_ir(ir), .o_cc(cc), .o_state(state),
        .o_halted(halted), .o_illegal(illegal)
    );

    always @(posedge clk) begin
        if (ld_mem) tb_mem[ld_addr] <= ld_data;
        else if (mem_we) tb_mem[mem_addr] <= mem_wdata;
        if (ld_rf) tb_rf[ld_addr[2:0]] <= ld_data;
        else if (rf_we) tb_rf[rf_dr] <= rf_wdata;
    end

    assign mem_rdata   = tb_mem[mem_addr];
    assign rf_sr1_data = tb_rf[rf_sr1];
    assign rf_sr2_data = tb_rf[rf_sr2];

    always_comb begin
        case (alu_op)
            2'b00:   alu_y = alu_a + alu_b;
            2'b01:   alu_y = alu_a & alu_b;
            2'b10:   alu_y = ~alu_a;
            default: alu_y = 16'h0000;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Fill the model with TRAPs and random registers; directed tests patch it.
    task automatic prep();
        for (int i = 0; i < 128; i++) m_mem[i] = 16'hF025;
        for (int i = 0; i < 8; i++) m_rf[i] = 16'($urandom);
    endtask

    // Copy the model image into the environment with reset held, then release.
    task automatic load_all(input logic run_after);
        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 128; i++) begin
            ld_mem = 1'b1; ld_addr = 7'(i); ld_data = m_mem[i];
            @(negedge clk);
        end
        ld_mem = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ld_rf = 1'b1; ld_addr = 7'(i); ld_data = m_rf[i];
            @(negedge clk);
        end
        ld_rf = 1'b0;
        check("rst_rf_we", rf_we, 0);
        check("rst_mem_we", mem_we, 0);
        rst = 1'b0;
        run = run_after;
        #1;
        check("rst_pc", pc, 0);
        check("rst_ir", ir, 0);
        check("rst_cc", cc, 3'b010);
        check("rst_state", state, 0);
        check("rst_halted", halted, 0);
        check("rst_illegal", illegal, 0);
        m_pc = 16'h0000;
        m_cc = 3'b010;
        m_halted = 1'b0;
        m_illegal = 1'b0;
    endtask

    // Executes the instruction at m_pc in ISA terms and reports the expected
    // cycle count and the expected number of register / memory writes.
    task automatic model_step(output int lat, output int rfw, output int memw);
        logic [15:0] iw, pc1, off, a, b, res, addr;
        logic        wr;
        iw   = m_mem[m_pc[6:0]];
        pc1  = m_pc + 16'd1;
        off  = {{7{iw[8]}}, iw[8:0]};
        m_pc = pc1;
        lat = 3; rfw = 0; memw = 0; wr = 1'b0; res = 16'h0000;
        case (iw[15:12])
            4'h1, 4'h5: begin
                a = m_rf[iw[8:6]];
                b = iw[5] ? {{11{iw[4]}}, iw[4:0]} : m_rf[iw[2:0]];
                res = (iw[15:12] == 4'h1) ? a + b : a & b;
                wr = 1'b1;
            end
            4'h9: begin res = ~m_rf[iw[8:6]]; wr = 1'b1; end
            4'h0: begin
                if ((iw[11] && m_cc[2]) || (iw[10] && m_cc[1]) || (iw[9] && m_cc[0]))
                    m_pc = pc1 + off;
            end
            4'hE: begin res = pc1 + off; wr = 1'b1; end
            4'hC: m_pc = m_rf[iw[8:6]];
            4'h2: begin
                addr = pc1 + off; res = m_mem[addr[6:0]]; wr = 1'b1; lat = 5;
            end
            4'h3: begin
                addr = pc1 + off; m_mem[addr[6:0]] = m_rf[iw[11:9]]; memw = 1; lat = 4;
            end
            4'hF: begin m_halted = 1'b1; lat = 2; end
            default: begin m_halted = 1'b1; m_illegal = 1'b1; lat = 2; end
        endcase
        if (wr) begin
            m_rf[iw[11:9]] = res;
            m_cc = {res[15], res == 16'h0000, !res[15] && res != 16'h0000};
            rfw = 1;
        end
    endtask

    // Steps the DUT from one FETCH to the next FETCH (or HALT), counting
    // cycles and write strobes; bounded so that a stuck FSM still finishes.
    task automatic run_instr(output int cyc, output int rfw, output int memw);
        cyc = 0; rfw = 0; memw = 0;
        do begin
            if (rf_we) rfw++;
            if (mem_we) memw++;
            @(negedge clk);
            cyc++;
        end while (state != 3'd0 && state != 3'd5 && cyc < 12);
    endtask

    task automatic run_prog(input int max_instr);
        int el, er, em, gl, gr, gm;
        for (int k = 0; k < max_instr; k++) begin
            if (m_halted) break;
            model_step(el, er, em);
            run_instr(gl, gr, gm);
            check("latency", gl, el);
            check("rf_we_pulses", gr, er);
            check("mem_we_pulses", gm, em);
            check("pc", pc, m_pc);
            check("cc", cc, m_cc);
            check("halted", halted, m_halted);
            check("illegal", illegal, m_illegal);
        end
        if (m_halted) begin
            repeat (4) @(negedge clk);
            check("halt_state", state, 3'b101);
            check("halt_pc_frozen", pc, m_pc);
            check("halt_sticky", halted, 1);
        end
        for (int i = 0; i < 8; i++) check($sformatf("reg[%0d]", i), tb_rf[i], m_rf[i]);
        for (int i = 0; i < 128; i++) check($sformatf("mem[%0d]", i), tb_mem[i], m_mem[i]);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        int sel;
        logic [3:0] ill [7];
        ill = '{4'h4, 4'h6, 4'h7, 4'h8, 4'hA, 4'hB, 4'hD};
        w   = 16'($urandom);
        sel = $urandom_range(0, 99);
        if      (sel < 18) w[15:12] = 4'h1;
        else if (sel < 32) w[15:12] = 4'h5;
        else if (sel < 40) w[15:12] = 4'h9;
        else if (sel < 55) w[15:12] = 4'h0;
        else if (sel < 67) w[15:12] = 4'h2;
        else if (sel < 79) w[15:12] = 4'h3;
        else if (sel < 89) w[15:12] = 4'hE;
        else if (sel < 93) w[15:12] = 4'hC;
        else if (sel < 95) w[15:12] = 4'hF;
        else               w[15:12] = ill[$urandom_range(0, 6)];
        return w;
    endfunction

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ADD immediate: R1 = 5 + 1
        prep();
        m_rf[1] = 16'd5;
        m_mem[0] = 16'h1261;
        load_all(1'b1);
        run_prog(2);
        check("add_r1", tb_rf[1], 16'd6);
        check("add_cc", cc, 3'b001);

        // ST R2,#4 then LD R3,#3, both addressing word 5
        prep();
        m_rf[2] = 16'h8000;
        m_mem[0] = 16'h3404;
        m_mem[1] = 16'h2603;
        load_all(1'b1);
        run_prog(3);
        check("st_mem5", tb_mem[5], 16'h8000);
        check("ld_r3", tb_rf[3], 16'h8000);
        check("ld_cc", cc, 3'b100);

        // BRz taken after a zero result, then not taken after a positive one
        prep();
        m_mem[0] = 16'h5020;
        m_mem[1] = 16'h0402;
        m_mem[4] = 16'h1021;
        m_mem[5] = 16'h0402;
        load_all(1'b1);
        run_prog(2);
        check("brz_taken_pc", pc, 16'd4);
        run_prog(2);
        check("brz_not_taken_pc", pc, 16'd6);
        run_prog(1);

        // TRAP
        prep();
        m_mem[0] = 16'hF025;
        load_all(1'b1);
        run_prog(1);
        check("trap_halted", halted, 1);
        check("trap_illegal", illegal, 0);
        check("trap_state", state, 3'b101);
        check("trap_pc", pc, 16'd1);

        // Illegal opcode
        prep();
        m_mem[0] = 16'hD000;
        load_all(1'b1);
        run_prog(1);
        check("ill_halted", halted, 1);
        check("ill_illegal", illegal, 1);

        // Reset while an LD sits in OPERFETCH
        prep();
        m_rf[3] = 16'h5555;
        m_mem[0] = 16'h2603;
        m_mem[4] = 16'h1234;
        load_all(1'b1);
        repeat (3) @(negedge clk);
        check("midld_state", state, 3'd3);
        rst = 1'b1;
        #1;
        check("midld_rst_rf_we", rf_we, 0);
        check("midld_rst_state", state, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midld_pc", pc, 0);
        check("midld_cc", cc, 3'b010);
        check("midld_state_after", state, 0);
        check("midld_r3_kept", tb_rf[3], 16'h5555);

        // Run held low out of reset
        prep();
        m_mem[0] = 16'h1261;
        load_all(1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_pc", pc, 0);
            check("stall_state", state, 0);
            check("stall_strobes", {rf_we, mem_we}, 0);
        end
        run = 1'b1;
        @(negedge clk);
        check("stall_release_state", state, 3'd1);
        check("stall_release_pc", pc, 16'd1);
        check("stall_release_ir", ir, 16'h1261);

        // Randomized programs
        for (int p = 0; p < 10; p++) begin
            for (int i = 0; i < 128; i++) m_mem[i] = rand_instr();
            for (int i = 0; i < 8; i++) m_rf[i] = 16'($urandom);
            load_all(1'b1);
            run_prog(60);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
